// File: rtl/pipediv_pkg.sv
// Shared constants for the pipelined restoring divider (pipediv_stream).
// The optional signed mode is enabled by defining PIPEDIV_SIGNED_EN.
package pipediv_pkg;

  // Fill bits for the result when the divisor is zero.
  localparam logic DBZ_QUO_BIT = 1'b1;
  localparam logic DBZ_REM_BIT = 1'b0;

  // Default widths shared by the top level and its stages.
  localparam int DEF_DIVIDEND = 8;
  localparam int DEF_DIVISOR  = 4;
  localparam int DEF_TAG_W    = 4;

endpackage

// File: rtl/pipediv_stage.sv
// One restoring-division step and its pipeline register. The LAST instance
// also applies the sign and divide-by-zero fix-ups before registering.
module pipediv_stage
  import pipediv_pkg::*;
#(
  parameter int DIVIDEND = DEF_DIVIDEND,
  parameter int DIVISOR  = DEF_DIVISOR,
  parameter int TAG_W    = DEF_TAG_W,
  parameter bit LAST     = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                en,
  input  logic                prev_valid,
  input  logic [DIVISOR-1:0]  prev_rem,
  input  logic [DIVIDEND-1:0] prev_dvd,
  input  logic [DIVIDEND-1:0] prev_quo,
  input  logic [DIVISOR-1:0]  prev_dvs,
  input  logic [TAG_W-1:0]    prev_tag,
  input  logic                prev_dbz,
  input  logic                prev_qneg,
  input  logic                prev_rneg,
  output logic                valid_r,
  output logic [DIVISOR-1:0]  rem_r,
  output logic [DIVIDEND-1:0] dvd_r,
  output logic [DIVIDEND-1:0] quo_r,
  output logic [DIVISOR-1:0]  dvs_r,
  output logic [TAG_W-1:0]    tag_r,
  output logic                dbz_r,
  output logic                qneg_r,
  output logic                rneg_r
);

  logic [DIVISOR:0]    trial_s;
  logic [DIVISOR:0]    diff_s;
  logic                qbit_s;
  logic [DIVIDEND-1:0] quo_s;
  logic [DIVISOR-1:0]  rem_s;
  logic [DIVIDEND-1:0] quo_fix_s;
  logic [DIVISOR-1:0]  rem_fix_s;
  logic                unused_s;

  // The extra top bit keeps the compare exact when the shifted remainder overflows DIVISOR bits.
  assign trial_s  = {prev_rem, prev_dvd[DIVIDEND-1]};
  assign diff_s   = trial_s - {1'b0, prev_dvs};
  assign qbit_s   = (trial_s >= {1'b0, prev_dvs});
  assign unused_s = ^{diff_s[DIVISOR], prev_quo[DIVIDEND-1]};

  // Restoring step, then final-stage sign and divide-by-zero overrides.
  always_comb begin
    quo_s     = {prev_quo[DIVIDEND-2:0], qbit_s};
    rem_s     = qbit_s ? diff_s[DIVISOR-1:0] : trial_s[DIVISOR-1:0];
    quo_fix_s = quo_s;
    rem_fix_s = rem_s;
    if (LAST && prev_dbz) begin
      quo_fix_s = {DIVIDEND{DBZ_QUO_BIT}};
      rem_fix_s = {DIVISOR{DBZ_REM_BIT}};
    end else if (LAST) begin
      quo_fix_s = prev_qneg ? -quo_s : quo_s;
      rem_fix_s = prev_rneg ? -rem_s : rem_s;
    end else begin
      quo_fix_s = quo_s;
      rem_fix_s = rem_s;
    end
  end

  // Stage register; holds everything, bubbles included, while the pipe is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      rem_r   <= {DIVISOR{1'b0}};
      dvd_r   <= {DIVIDEND{1'b0}};
      quo_r   <= {DIVIDEND{1'b0}};
      dvs_r   <= {DIVISOR{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      dbz_r   <= 1'b0;
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
    end else if (en) begin
      valid_r <= prev_valid;
      rem_r   <= rem_fix_s;
      dvd_r   <= {prev_dvd[DIVIDEND-2:0], 1'b0};
      quo_r   <= quo_fix_s;
      dvs_r   <= prev_dvs;
      tag_r   <= prev_tag;
      dbz_r   <= prev_dbz;
      qneg_r  <= prev_qneg;
      rneg_r  <= prev_rneg;
    end
  end

endmodule

// File: rtl/pipediv_stream.sv
// Pipelined restoring divider, one quotient bit per stage, valid/ready stream
// with global stall. Define PIPEDIV_SIGNED_EN to add the is_signed port.
module pipediv_stream
  import pipediv_pkg::*;
#(
  parameter int DIVIDEND = DEF_DIVIDEND,
  parameter int DIVISOR  = DEF_DIVISOR,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  input  logic [TAG_W-1:0]    in_tag,
`ifdef PIPEDIV_SIGNED_EN
  input  logic                is_signed,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder,
  output logic                div_by_zero,
  output logic [TAG_W-1:0]    out_tag
);

  logic                adv_s;
  logic                sgn_s;
  logic                dvd_neg_s;
  logic                dvs_neg_s;
  logic [DIVIDEND-1:0] dvd_mag_s;
  logic [DIVISOR-1:0]  dvs_mag_s;
  logic                unused_s;

  logic                in_valid_r;
  logic [DIVIDEND-1:0] in_dvd_r;
  logic [DIVISOR-1:0]  in_dvs_r;
  logic [TAG_W-1:0]    in_tag_r;
  logic                in_dbz_r;
  logic                in_qneg_r;
  logic                in_rneg_r;

  logic                stg_valid_r [DIVIDEND];
  logic [DIVISOR-1:0]  stg_rem_r   [DIVIDEND];
  logic [DIVIDEND-1:0] stg_dvd_r   [DIVIDEND];
  logic [DIVIDEND-1:0] stg_quo_r   [DIVIDEND];
  logic [DIVISOR-1:0]  stg_dvs_r   [DIVIDEND];
  logic [TAG_W-1:0]    stg_tag_r   [DIVIDEND];
  logic                stg_dbz_r   [DIVIDEND];
  logic                stg_qneg_r  [DIVIDEND];
  logic                stg_rneg_r  [DIVIDEND];

`ifdef PIPEDIV_SIGNED_EN
  assign sgn_s = is_signed;
`else
  assign sgn_s = 1'b0;
`endif

  // A full output blocks the whole pipe; a drained or accepted one lets it move.
  assign adv_s    = !stg_valid_r[DIVIDEND-1] || out_ready;
  assign in_ready = adv_s;

  // Signed operands are reduced to magnitudes; signs travel with the operation.
  assign dvd_neg_s = sgn_s & dividend[DIVIDEND-1];
  assign dvs_neg_s = sgn_s & divisor[DIVISOR-1];
  assign dvd_mag_s = dvd_neg_s ? -dividend : dividend;
  assign dvs_mag_s = dvs_neg_s ? -divisor : divisor;

  // Operand capture register feeding the first restoring stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_valid_r <= 1'b0;
      in_dvd_r   <= {DIVIDEND{1'b0}};
      in_dvs_r   <= {DIVISOR{1'b0}};
      in_tag_r   <= {TAG_W{1'b0}};
      in_dbz_r   <= 1'b0;
      in_qneg_r  <= 1'b0;
      in_rneg_r  <= 1'b0;
    end else if (adv_s) begin
      in_valid_r <= in_valid;
      in_dvd_r   <= dvd_mag_s;
      in_dvs_r   <= dvs_mag_s;
      in_tag_r   <= in_tag;
      in_dbz_r   <= (divisor == {DIVISOR{1'b0}});
      in_qneg_r  <= dvd_neg_s ^ dvs_neg_s;
      in_rneg_r  <= dvd_neg_s;
    end
  end

  for (genvar k = 0; k < DIVIDEND; k++) begin : g_stage
    if (k == 0) begin : g_first
      pipediv_stage #(
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .TAG_W(TAG_W), .LAST(1'b0)
      ) u_stage (
        .clock(clock), .reset_n(reset_n), .en(adv_s),
        .prev_valid(in_valid_r), .prev_rem({DIVISOR{1'b0}}), .prev_dvd(in_dvd_r),
        .prev_quo({DIVIDEND{1'b0}}), .prev_dvs(in_dvs_r), .prev_tag(in_tag_r),
        .prev_dbz(in_dbz_r), .prev_qneg(in_qneg_r), .prev_rneg(in_rneg_r),
        .valid_r(stg_valid_r[k]), .rem_r(stg_rem_r[k]), .dvd_r(stg_dvd_r[k]),
        .quo_r(stg_quo_r[k]), .dvs_r(stg_dvs_r[k]), .tag_r(stg_tag_r[k]),
        .dbz_r(stg_dbz_r[k]), .qneg_r(stg_qneg_r[k]), .rneg_r(stg_rneg_r[k])
      );
    end else begin : g_rest
      pipediv_stage #(
        .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .TAG_W(TAG_W), .LAST(k == DIVIDEND - 1)
      ) u_stage (
        .clock(clock), .reset_n(reset_n), .en(adv_s),
        .prev_valid(stg_valid_r[k-1]), .prev_rem(stg_rem_r[k-1]), .prev_dvd(stg_dvd_r[k-1]),
        .prev_quo(stg_quo_r[k-1]), .prev_dvs(stg_dvs_r[k-1]), .prev_tag(stg_tag_r[k-1]),
        .prev_dbz(stg_dbz_r[k-1]), .prev_qneg(stg_qneg_r[k-1]), .prev_rneg(stg_rneg_r[k-1]),
        .valid_r(stg_valid_r[k]), .rem_r(stg_rem_r[k]), .dvd_r(stg_dvd_r[k]),
        .quo_r(stg_quo_r[k]), .dvs_r(stg_dvs_r[k]), .tag_r(stg_tag_r[k]),
        .dbz_r(stg_dbz_r[k]), .qneg_r(stg_qneg_r[k]), .rneg_r(stg_rneg_r[k])
      );
    end
  end

  assign out_valid   = stg_valid_r[DIVIDEND-1];
  assign quotient    = stg_quo_r[DIVIDEND-1];
  assign remainder   = stg_rem_r[DIVIDEND-1];
  assign div_by_zero = stg_dbz_r[DIVIDEND-1];
  assign out_tag     = stg_tag_r[DIVIDEND-1];

  assign unused_s = ^{stg_dvd_r[DIVIDEND-1], stg_dvs_r[DIVIDEND-1],
                      stg_qneg_r[DIVIDEND-1], stg_rneg_r[DIVIDEND-1]};

endmodule

// File: tb/tb_pipediv_stream.sv
// Scoreboard bench for pipediv_stream: randomized and directed stimulus checked
// against an arithmetic reference model. Honours PIPEDIV_SIGNED_EN when defined.
`timescale 1ns/1ps
module tb_pipediv_stream;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic [TW-1:0] out_tag;
  logic          cur_sgn;
`ifdef PIPEDIV_SIGNED_EN
  logic          is_signed = 1'b0;
  assign cur_sgn = is_signed;
`else
  assign cur_sgn = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          dbz;
    logic [TW-1:0] tag;
  } res_t;

  res_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  logic hold_chk = 1'b0;
  res_t held;

  pipediv_stream #(.DIVIDEND(DW), .DIVISOR(SW), .TAG_W(TW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
`ifdef PIPEDIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  // Reference: plain integer division; SV int '/' and '%' truncate toward zero.
  function automatic res_t model(input logic [DW-1:0] a, input logic [SW-1:0] b,
                                 input logic [TW-1:0] t, input logic s);
    res_t e;
    int   sa, sb;
    e.tag = t;
    e.dbz = (b == {SW{1'b0}});
    if (e.dbz) begin
      e.q = {DW{1'b1}};
      e.r = {SW{1'b0}};
    end else if (s) begin
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      e.q = DW'(sa / sb);
      e.r = SW'(sa % sb);
    end else begin
      e.q = DW'(int'(a) / int'(b));
      e.r = SW'(int'(a) % int'(b));
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on output transfer, checks stall stability, pushes on input transfer.
  always @(negedge clock) begin
    res_t act, exp;
    act = '{q: quotient, r: remainder, dbz: div_by_zero, tag: out_tag};
    if (!reset_n) begin
      sbq.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        checks++;
        if (act !== held || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold: got %h expected %h", act, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got %h expected none", act);
        end else begin
          exp = sbq.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL result q/r/dbz/tag: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     act.q, act.r, act.dbz, act.tag, exp.q, exp.r, exp.dbz, exp.tag);
          end
        end
      end
      hold_chk = out_valid && !out_ready;
      held     = act;
      if (in_valid && in_ready) sbq.push_back(model(dividend, divisor, in_tag, cur_sgn));
    end
  end

  task automatic send_one(input logic [DW-1:0] a, input logic [SW-1:0] b,
                          input logic [TW-1:0] t, input logic s);
    in_valid = 1'b1; dividend = a; divisor = b; in_tag = t;
`ifdef PIPEDIV_SIGNED_EN
    is_signed = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (DW) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    check("reset_tag", out_tag, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_reset_out_valid", out_valid, 0);

    // 200/7 tag 3: visible exactly DW edges after acceptance.
    out_ready = 1'b1;
    in_valid = 1'b1; dividend = 8'd200; divisor = 4'd7; in_tag = 4'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= DW; i++) begin
      @(posedge clock); #1;
      if (i == DW - 1) check("latency_early", out_valid, 0);
    end
    check("latency_valid", out_valid, 1);
    check("q_200_7", quotient, 28);
    check("r_200_7", remainder, 4);
    check("dbz_200_7", div_by_zero, 0);
    check("tag_200_7", out_tag, 3);

    send_one(8'd15, 4'd0, 4'd9, 1'b0);
    check("dbz_q", quotient, 255);
    check("dbz_r", remainder, 0);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_tag", out_tag, 9);

`ifdef PIPEDIV_SIGNED_EN
    send_one(8'h9C, 4'h7, 4'd1, 1'b1);
    check("s_q_m100_7", quotient, 8'hF2);
    check("s_r_m100_7", remainder, 4'hE);
    send_one(8'h80, 4'hF, 4'd2, 1'b1);
    check("s_q_m128_m1", quotient, 8'h80);
    check("s_r_m128_m1", remainder, 0);
    check("s_dbz_m128_m1", div_by_zero, 0);
    is_signed = 1'b0;
`endif

    // Exhaustive unsigned sweep, back to back.
    for (int i = 0; i < 4096; i++) begin
      in_valid = 1'b1;
      dividend = DW'(i >> 4);
      divisor  = SW'(i);
      in_tag   = TW'(i >> 2);
      #1 check("sweep_in_ready", in_ready, 1);
      @(posedge clock); #1;
    end

    // Stall with a full pipe: nothing enters, outputs freeze.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dividend = DW'($urandom); divisor = SW'($urandom); in_tag = TW'($urandom);
      #1 check("stall_in_ready", in_ready, 0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      dividend  = DW'($urandom);
      divisor   = SW'($urandom);
      in_tag    = TW'($urandom);
`ifdef PIPEDIV_SIGNED_EN
      is_signed = 1'($urandom);
`endif
      @(posedge clock); #1;
    end

    // Reset with operations in flight; none may reappear.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; dividend = DW'($urandom); divisor = SW'($urandom); in_tag = TW'(i);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("inflight_out_valid", out_valid, 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    check("async_reset_quotient", quotient, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < DW + 2; i++) begin
      @(posedge clock); #1;
      check("no_stale_result", out_valid, 0);
    end

    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; dividend = DW'($urandom); divisor = SW'($urandom); in_tag = TW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clock); #1;
    end

    // Drain with a bounded budget.
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4 * DW && sbq.size() > 0; i++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    check("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
